// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multi-cycle control unit and the shared-memory datapath.
interface multicycle_control_unit_if #(
    parameter int unsigned ALU_OP_W = 2,
    parameter int unsigned COUNT_W  = 16
);
    logic [5:0]          instr_op;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_write_cond;
    logic [1:0]          pc_source;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALU_OP_W-1:0] alu_op;
    logic                illegal_op;
    logic [3:0]          state;
    logic [COUNT_W-1:0]  retired;

    // Control unit side
    modport master (
        input  instr_op, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, illegal_op, state, retired
    );

    // Datapath side
    modport slave (
        output instr_op, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, illegal_op, state, retired
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control unit: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready, flags illegal opcodes and counts retired instructions.
module multicycle_control_unit #(
    parameter int unsigned ALU_OP_W = 2,
    parameter int unsigned COUNT_W  = 16,
    parameter int unsigned EN_JUMP  = 1
) (
    input logic                       clk,
    input logic                       rst,
    multicycle_control_unit_if.master ctrl
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_ADDIEX = 4'd8,
        S_ADDIWB = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t             state_q;
    state_t             state_d;
    logic [5:0]         op_q;
    logic [COUNT_W-1:0] retired_q;
    logic               retire;
    logic               decode_illegal;

    // Next-state selection, retirement and illegal-opcode detection
    always_comb begin
        state_d        = S_FETCH;
        retire         = 1'b0;
        decode_illegal = 1'b0;
        case (state_q)
            S_FETCH:  state_d = ctrl.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (ctrl.instr_op)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J: begin
                        if (EN_JUMP != 0) state_d = S_JUMP;
                        else              decode_illegal = 1'b1;
                    end
                    default:      decode_illegal = 1'b1;
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = ctrl.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  retire  = 1'b1;
            S_MEMWR: begin
                if (ctrl.mem_ready) retire  = 1'b1;
                else                state_d = S_MEMWR;
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  retire  = 1'b1;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: retire  = 1'b1;
            S_BRANCH: retire  = 1'b1;
            S_JUMP:   retire  = 1'b1;
            default:  state_d = S_FETCH;
        endcase
    end

    // State, latched opcode and retired counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) op_q <= ctrl.instr_op;
            if (retire) retired_q <= retired_q + COUNT_W'(1);
        end
    end

    // Datapath controls decoded from the current state; forced low during reset
    always_comb begin
        ctrl.pc_write      = 1'b0;
        ctrl.pc_write_cond = 1'b0;
        ctrl.pc_source     = 2'b00;
        ctrl.i_or_d        = 1'b0;
        ctrl.mem_read      = 1'b0;
        ctrl.mem_write     = 1'b0;
        ctrl.ir_write      = 1'b0;
        ctrl.reg_dst       = 1'b0;
        ctrl.mem_to_reg    = 1'b0;
        ctrl.reg_write     = 1'b0;
        ctrl.alu_src_a     = 1'b0;
        ctrl.alu_src_b     = 2'b00;
        ctrl.alu_op        = '0;
        ctrl.illegal_op    = 1'b0;
        ctrl.state         = 4'd0;
        ctrl.retired       = '0;
        if (!rst) begin
            ctrl.state      = 4'(state_q);
            ctrl.retired    = retired_q;
            ctrl.illegal_op = decode_illegal;
            case (state_q)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = 2'b01;
                    ctrl.ir_write  = ctrl.mem_ready;
                    ctrl.pc_write  = ctrl.mem_ready;
                end
                S_DECODE: ctrl.alu_src_b = 2'b11;
                S_MEMADR, S_ADDIEX: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.i_or_d   = 1'b1;
                end
                S_MEMWB: begin
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.i_or_d    = 1'b1;
                end
                S_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_op    = ALU_OP_W'(2'b10);
                end
                S_ALUWB: begin
                    ctrl.reg_dst   = 1'b1;
                    ctrl.reg_write = 1'b1;
                end
                S_ADDIWB: ctrl.reg_write = 1'b1;
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_op        = ALU_OP_W'(2'b01);
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = 2'b01;
                end
                S_JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = 2'b10;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: instruction-level reference sequences,
// randomized opcodes and stalls, two configurations (4-bit counter with jump,
// 16-bit counter without jump), each run while the other is held in reset.
module tb_multicycle_control_unit;
    logic       clk = 1'b0;
    logic       rst1;
    logic       rst2;
    logic [5:0] op_in;
    logic       rdy_in;

    int n_cmp = 0;
    int n_err = 0;
    int cnt1  = 0;
    int cnt2  = 0;

    multicycle_control_unit_if #(.ALU_OP_W(2), .COUNT_W(4))  bus1 ();
    multicycle_control_unit_if #(.ALU_OP_W(2), .COUNT_W(16)) bus2 ();

    assign bus1.instr_op  = op_in;
    assign bus1.mem_ready = rdy_in;
    assign bus2.instr_op  = op_in;
    assign bus2.mem_ready = rdy_in;

    multicycle_control_unit #(.ALU_OP_W(2), .COUNT_W(4), .EN_JUMP(1)) dut1 (
        .clk  (clk),
        .rst  (rst1),
        .ctrl (bus1.master)
    );

    multicycle_control_unit #(.ALU_OP_W(2), .COUNT_W(16), .EN_JUMP(0)) dut2 (
        .clk  (clk),
        .rst  (rst2),
        .ctrl (bus2.master)
    );

    always #5 clk = ~clk;

    logic [20:0] vec1, vec2;
    logic [15:0] ret1, ret2;
    assign vec1 = {bus1.pc_write, bus1.pc_write_cond, bus1.pc_source, bus1.i_or_d,
                   bus1.mem_read, bus1.mem_write, bus1.ir_write, bus1.reg_dst,
                   bus1.mem_to_reg, bus1.reg_write, bus1.alu_src_a, bus1.alu_src_b,
                   bus1.alu_op, bus1.illegal_op, bus1.state};
    assign vec2 = {bus2.pc_write, bus2.pc_write_cond, bus2.pc_source, bus2.i_or_d,
                   bus2.mem_read, bus2.mem_write, bus2.ir_write, bus2.reg_dst,
                   bus2.mem_to_reg, bus2.reg_write, bus2.alu_src_a, bus2.alu_src_b,
                   bus2.alu_op, bus2.illegal_op, bus2.state};
    assign ret1 = 16'(bus1.retired);
    assign ret2 = bus2.retired;

    // Reference instruction trace: state code, mem_ready and illegal flag per cycle
    int q_state[$];
    bit q_rdy[$];
    bit q_ill[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected control word for one cycle, straight from the state table
    function automatic logic [20:0] exp_vec(input int st, input bit rdy, input bit ill);
        logic pw, pwc, iod, mr, mw, irw, rd, m2r, rw, asa, il;
        logic [1:0] ps, asb, aop;
        {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, asa, il} = '0;
        ps = 2'b00; asb = 2'b00; aop = 2'b00;
        case (st)
            0:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            1:  begin asb = 2'b11; il = ill; end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iod = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mw = 1; iod = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; asb = 2'b10; end
            9:  begin rw = 1; end
            10: begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
            11: begin pw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pw, pwc, ps, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop, il, 4'(st)};
    endfunction

    function automatic bit is_legal(input logic [5:0] op, input bit en_j);
        return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
               (op == 6'b001000) || (op == 6'b000100) || (en_j && op == 6'b000010);
    endfunction

    task automatic push(input int st, input bit rdy, input bit ill);
        q_state.push_back(st);
        q_rdy.push_back(rdy);
        q_ill.push_back(ill);
    endtask

    // Build the whole cycle trace of one instruction from its class
    task automatic build(input logic [5:0] op, input bit en_j, input int sf, input int sm);
        q_state.delete(); q_rdy.delete(); q_ill.delete();
        for (int i = 0; i < sf; i++) push(0, 1'b0, 1'b0);
        push(0, 1'b1, 1'b0);
        push(1, 1'($urandom), !is_legal(op, en_j));
        if (!is_legal(op, en_j)) return;
        case (op)
            6'b000000: begin push(6, 1'($urandom), 0); push(7, 1'($urandom), 0); end
            6'b100011: begin
                push(2, 1'($urandom), 0);
                for (int i = 0; i < sm; i++) push(3, 1'b0, 0);
                push(3, 1'b1, 0);
                push(4, 1'($urandom), 0);
            end
            6'b101011: begin
                push(2, 1'($urandom), 0);
                for (int i = 0; i < sm; i++) push(5, 1'b0, 0);
                push(5, 1'b1, 0);
            end
            6'b001000: begin push(8, 1'($urandom), 0); push(9, 1'($urandom), 0); end
            6'b000100: push(10, 1'($urandom), 0);
            default:   push(11, 1'($urandom), 0);
        endcase
    endtask

    // Drive one cycle, compare at the falling edge, advance past the next rising edge
    task automatic step(input bit which, input int st, input bit rdy, input logic [5:0] op,
                        input bit ill);
        op_in  = (st == 1) ? op : 6'($urandom);
        rdy_in = rdy;
        @(negedge clk);
        chk($sformatf("ctrl%0d st%0d op%b", which + 1, st, op),
            64'(which ? vec2 : vec1), 64'(exp_vec(st, rdy, ill)));
        chk($sformatf("retired%0d st%0d", which + 1, st),
            64'(which ? ret2 : ret1), 64'(which ? cnt2 : cnt1));
        chk("idle_in_reset", 64'(which ? vec1 : vec2), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input bit which, input logic [5:0] op, input int sf, input int sm);
        build(op, !which, sf, sm);
        for (int i = 0; i < q_state.size(); i++) step(which, q_state[i], q_rdy[i], op, q_ill[i]);
        if (is_legal(op, !which)) begin
            if (which) cnt2 = (cnt2 + 1) % 65536;
            else       cnt1 = (cnt1 + 1) % 16;
        end
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 7))
            0:       return 6'b000000;
            1:       return 6'b100011;
            2:       return 6'b101011;
            3:       return 6'b001000;
            4:       return 6'b000100;
            5:       return 6'b000010;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        rst1   = 1'b1;
        rst2   = 1'b1;
        op_in  = 6'b100011;
        rdy_in = 1'b0;

        // Both units held in reset: every output low
        repeat (2) begin
            @(negedge clk);
            chk("reset vec1", 64'(vec1), 64'd0);
            chk("reset ret1", 64'(ret1), 64'd0);
            chk("reset vec2", 64'(vec2), 64'd0);
            chk("reset ret2", 64'(ret2), 64'd0);
            @(posedge clk);
            #1;
        end
        rst1 = 1'b0;

        // Directed: R-type, lw with a 3-cycle memory stall, beq, j, illegal
        run_instr(0, 6'b000000, 0, 0);
        run_instr(0, 6'b100011, 0, 3);
        run_instr(0, 6'b000100, 0, 0);
        run_instr(0, 6'b000010, 0, 0);
        run_instr(0, 6'b111111, 0, 0);
        run_instr(0, 6'b101011, 2, 1);

        // Randomized mix with random stalls
        repeat (150) run_instr(0, pick_op(), $urandom_range(0, 2), $urandom_range(0, 2));

        // Reset in the middle of a stalled store: no write, back to FETCH, counter cleared
        step(0, 0, 1'b1, 6'b101011, 1'b0);
        step(0, 1, 1'b1, 6'b101011, 1'b0);
        step(0, 2, 1'b1, 6'b101011, 1'b0);
        step(0, 5, 1'b0, 6'b101011, 1'b0);
        rst1   = 1'b1;
        rdy_in = 1'b1;
        @(negedge clk);
        chk("midreset vec1", 64'(vec1), 64'd0);
        chk("midreset ret1", 64'(ret1), 64'd0);
        @(posedge clk);
        #1;
        rst1 = 1'b0;
        cnt1 = 0;
        step(0, 0, 1'b0, 6'b000000, 1'b0);

        // Sixteen addi back to back wrap the 4-bit counter to zero
        repeat (16) run_instr(0, 6'b001000, 0, 0);
        run_instr(0, 6'b000100, 0, 0);

        // Second configuration: jump disabled, 16-bit counter
        rst1 = 1'b1;
        rst2 = 1'b0;
        run_instr(1, 6'b000010, 0, 0);
        run_instr(1, 6'b000100, 1, 0);
        run_instr(1, 6'b000000, 0, 0);
        repeat (40) run_instr(1, pick_op(), $urandom_range(0, 2), $urandom_range(0, 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
